// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 10;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_i, searching upward.
module uart_rr_pick
    import uart_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = last_i;
        cand    = '0;
        // Offsets 1..NUM_REQ; the last offset wraps back onto last_i itself.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = last_i + IDX_W'(k);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Four-requester UART transmitter: round-robin arbitration in IDLE, then an 8N1 frame
// timed by a clk_in-domain bit-cycle counter.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned Clock_Rate = 100000000,
    parameter int unsigned Baud_Rate  = 9600
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [3:0]  req_in,
    input  logic [31:0] data_in,
    output logic [3:0]  ack_out,
    output logic [1:0]  grant_out,
    output logic        busy_out,
    output logic        tx_out
);

    localparam int unsigned CLKS_PER_BIT = Clock_Rate / Baud_Rate;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W        = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_rate_guard
        $error("uart_tx_arbiter: Clock_Rate / Baud_Rate must be at least 2");
    end

    if (FRAME_BITS != DATA_BITS + 2) begin : g_frame_guard
        $error("uart_tx_arbiter: frame must be start + data + stop");
    end

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [BIT_W-1:0]       bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   tx_q;
    logic                   busy_q;
    logic [NUM_REQ-1:0]     ack_q;
    logic [IDX_W-1:0]       grant_q;

    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic                   bit_end;

    uart_rr_pick u_pick (
        .req_i   (req_in),
        .last_i  (grant_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            grant_q <= '1;
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                    bit_q  <= '0;
                    if (pick_valid) begin
                        state_q <= ST_START;
                        grant_q <= pick_idx;
                        shift_q <= data_in[{pick_idx, 3'b000} +: DATA_BITS];
                        ack_q   <= onehot(pick_idx);
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_q <= ST_DATA;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == BIT_LAST) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack_out   = ack_q;
    assign grant_out = grant_q;
    assign busy_out  = busy_q;
    assign tx_out    = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with 16 clocks per bit.
module tb_uart_tx_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [3:0]  req_in;
    logic [31:0] data_in;
    logic [3:0]  ack_out;
    logic [1:0]  grant_out;
    logic        busy_out;
    logic        tx_out;

    int n_checks = 0;
    int n_errors = 0;
    int gap;

    uart_tx_arbiter #(
        .Clock_Rate (16),
        .Baud_Rate  (1)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .req_in    (req_in),
        .data_in   (data_in),
        .ack_out   (ack_out),
        .grant_out (grant_out),
        .busy_out  (busy_out),
        .tx_out    (tx_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    // Ticks until an ack appears; gap is the number of edges waited.
    task automatic wait_grant(output int g);
        g = 0;
        do begin
            tick();
            g++;
        end while (ack_out == 4'b0000 && g < 64);
        if (ack_out == 4'b0000)
            check("grant_timeout", 32'(g), 32'd0);
    endtask

    // Called just after the grant edge; walks all 160 frame cycles and the first idle cycle.
    task automatic run_frame(input logic [7:0] b, input logic [1:0] who, input string name,
                             input logic chg, input logic [3:0] chg_req, input logic [31:0] chg_data);
        logic [9:0] lvl;
        int match_cnt [10];
        int busy_cnt;
        int ack_cnt;
        lvl = {1'b1, b, 1'b0};
        busy_cnt = 0;
        ack_cnt = 0;
        for (int k = 0; k < 10; k++) match_cnt[k] = 0;
        check({name, "_ack"}, 32'(ack_out), 32'(4'b0001 << who));
        check({name, "_grant"}, 32'(grant_out), 32'(who));
        for (int c = 0; c < 160; c++) begin
            if (tx_out === lvl[c / 16]) match_cnt[c / 16]++;
            if (busy_out === 1'b1) busy_cnt++;
            if (ack_out != 4'b0000) ack_cnt++;
            if (chg && c == 40) begin
                req_in  = chg_req;
                data_in = chg_data;
            end
            tick();
        end
        for (int k = 0; k < 10; k++)
            check($sformatf("%s_bit%0d_cycles", name, k), 32'(match_cnt[k]), 32'd16);
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd160);
        check({name, "_ack_pulses"}, 32'(ack_cnt), 32'd1);
        check({name, "_end_busy"}, 32'(busy_out), 32'd0);
        check({name, "_end_tx"}, 32'(tx_out), 32'd1);
    endtask

    initial begin
        rst_in  = 1'b1;
        req_in  = 4'b0000;
        data_in = 32'h0;
        repeat (3) tick();
        check("rst_tx", 32'(tx_out), 32'd1);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_ack", 32'(ack_out), 32'd0);
        check("rst_grant", 32'(grant_out), 32'd3);
        rst_in = 1'b0;

        // Idle with no requests
        repeat (20) tick();
        check("idle_ack", 32'(ack_out), 32'd0);
        check("idle_busy", 32'(busy_out), 32'd0);
        check("idle_tx", 32'(tx_out), 32'd1);

        // Single frame, requester 0, 0xA5
        req_in  = 4'b0001;
        data_in = 32'h0000_00A5;
        wait_grant(gap);
        check("single_gap", 32'(gap), 32'd1);
        req_in = 4'b0000;
        run_frame(8'hA5, 2'd0, "single", 1'b0, 4'b0, 32'h0);

        // Fairness from reset: 0,1,2,3,0 with one idle cycle between frames
        rst_in  = 1'b1;
        req_in  = 4'b1111;
        data_in = 32'h4433_2211;
        tick();
        check("fair_rst_grant", 32'(grant_out), 32'd3);
        rst_in = 1'b0;
        for (int f = 0; f < 5; f++) begin
            logic [1:0] w;
            logic [7:0] bytes [4];
            bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
            w = 2'(f % 4);
            wait_grant(gap);
            check($sformatf("fair%0d_gap", f), 32'(gap), 32'd1);
            if (f == 4) req_in = 4'b0000;
            run_frame(bytes[w], w, $sformatf("fair%0d", f), 1'b0, 4'b0, 32'h0);
        end

        // Skip: grant 1, then 0101 -> 2, then 0
        req_in = 4'b0010;
        wait_grant(gap);
        run_frame(8'h22, 2'd1, "skip1", 1'b1, 4'b0101, 32'h4433_2211);
        check("skip_gap", 32'(gap), 32'd1);
        wait_grant(gap);
        run_frame(8'h33, 2'd2, "skip2", 1'b0, 4'b0, 32'h0);
        wait_grant(gap);
        req_in = 4'b0000;
        run_frame(8'h11, 2'd0, "skip0", 1'b0, 4'b0, 32'h0);

        // Inputs changed mid-frame are ignored until IDLE
        req_in  = 4'b0001;
        data_in = 32'h0000_005A;
        wait_grant(gap);
        run_frame(8'h5A, 2'd0, "ign0", 1'b1, 4'b1000, 32'hC300_0000);
        wait_grant(gap);
        req_in = 4'b0000;
        run_frame(8'hC3, 2'd3, "ign3", 1'b0, 4'b0, 32'h0);

        // Reset abort at cycle 50, requests 0011 held
        req_in  = 4'b0011;
        data_in = 32'h0000_3C96;
        wait_grant(gap);
        check("abort_first_grant", 32'(grant_out), 32'd0);
        repeat (50) tick();
        check("abort_pre_busy", 32'(busy_out), 32'd1);
        rst_in = 1'b1;
        #1;
        check("abort_tx", 32'(tx_out), 32'd1);
        check("abort_busy", 32'(busy_out), 32'd0);
        check("abort_ack", 32'(ack_out), 32'd0);
        check("abort_grant", 32'(grant_out), 32'd3);
        #1;
        rst_in = 1'b0;
        wait_grant(gap);
        check("abort_gap", 32'(gap), 32'd1);
        req_in = 4'b0000;
        run_frame(8'h96, 2'd0, "abort", 1'b0, 4'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
